// File: rtl/ram512_arbiter_pkg.sv
// rtl/ram512_arbiter_pkg.sv - shared widths, RAM depth and FSM encoding for ram512_arbiter
package ram512_arbiter_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int RAM_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RDATA = 2'b10
    } state_t;
endpackage

// File: rtl/ram512.sv
// rtl/ram512.sv - 512 x 16 single-port RAM with registered read data
module ram512 #(
    parameter int DATA_W = ram512_arbiter_pkg::DATA_W,
    parameter int ADDR_W = ram512_arbiter_pkg::ADDR_W,
    parameter int DEPTH  = ram512_arbiter_pkg::RAM_DEPTH
) (
    input  logic              clk,
    input  logic              e,
    input  logic              w,
    input  logic              r,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];

    // dout only moves on a read, so it holds the last read result.
    always_ff @(posedge clk) begin
        if (e && w) mem[adr] <= din;
        if (e && r) dout <= mem[adr];
    end
endmodule

// File: rtl/ram512_arbiter_rr_pick2.sv
// rtl/ram512_arbiter_rr_pick2.sv - two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);
    assign any = |req;
    // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
    assign gnt = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/ram512_arbiter.sv
// rtl/ram512_arbiter.sv - two-client round-robin req/ack controller owning one RAM512
module ram512_arbiter #(
    parameter int DATA_W = ram512_arbiter_pkg::DATA_W,
    parameter int ADDR_W = ram512_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);
    import ram512_arbiter_pkg::*;

    state_t            state, state_nxt;
    logic              last, g_l, we_l;
    logic [ADDR_W-1:0] adr_l;
    logic [DATA_W-1:0] din_l;
    logic              gnt, any, take;
    logic              ram_e, ram_w, ram_r;
    logic [DATA_W-1:0] ram_dout;

    rr_pick2 u_pick (
        .req  ({req1, req0}),
        .last (last),
        .gnt  (gnt),
        .any  (any)
    );

    assign take = (state == IDLE) && en && any;

    // Client inputs are captured only here, on the IDLE->ISSUE transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            g_l   <= 1'b0;
            we_l  <= 1'b0;
            adr_l <= '0;
            din_l <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                g_l   <= gnt;
                last  <= gnt;
                we_l  <= gnt ? we1  : we0;
                adr_l <= gnt ? adr1 : adr0;
                din_l <= gnt ? din1 : din0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        ram_e     = 1'b0;
        ram_w     = 1'b0;
        ram_r     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (take) state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_e     = 1'b1;
                ram_w     = we_l;
                ram_r     = ~we_l;
                ack0      = ~g_l;
                ack1      = g_l;
                state_nxt = we_l ? IDLE : RDATA;
            end
            RDATA: begin
                rvalid0   = ~g_l;
                rvalid1   = g_l;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    ram512 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk  (clk),
        .e    (ram_e),
        .w    (ram_w),
        .r    (ram_r),
        .adr  (adr_l),
        .din  (din_l),
        .dout (ram_dout)
    );

    assign rdata = ram_dout;
endmodule

// File: tb/tb_ram512_arbiter.sv
// tb/tb_ram512_arbiter.sv - directed self-checking bench for ram512_arbiter
module tb_ram512_arbiter;
    logic        clk = 1'b0;
    logic        rst, en;
    logic        req0, req1, we0, we1;
    logic [8:0]  adr0, adr1;
    logic [15:0] din0, din1;
    logic        ack0, ack1, rvalid0, rvalid1, busy;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;
    int n_ack0 = 0, n_ack1 = 0, n_rv0 = 0, n_rv1 = 0;

    ram512_arbiter dut (
        .clk(clk), .rst(rst), .en(en),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack0 === 1'b1) n_ack0++;
        if (ack1 === 1'b1) n_ack1++;
        if (rvalid0 === 1'b1) n_rv0++;
        if (rvalid1 === 1'b1) n_rv1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_port(input int p, input logic rq, input logic we,
                            input logic [8:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0 = rq; we0 = we; adr0 = a; din0 = d;
        end else begin
            req1 = rq; we1 = we; adr1 = a; din1 = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single access from an otherwise idle bus; expects ack one cycle after sampling.
    task automatic access(input int p, input logic we, input logic [8:0] a,
                          input logic [15:0] d, input logic [15:0] expd, input string name);
        int   cyc;
        logic ak, rv, rvo;
        set_port(p, 1'b1, we, a, d);
        cyc = 0;
        ak  = 1'b0;
        while (ak !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            ak = (p == 0) ? ack0 : ack1;
        end
        checks++;
        if (ak !== 1'b1 || cyc != 1) begin
            errors++;
            $display("FAIL %s_ack: ack=%b after %0d cycles, required 1 after 1", name, ak, cyc);
        end
        set_port(p, 1'b0, 1'b0, 9'h000, 16'h0000);
        if (!we) begin
            @(posedge clk); #1;
            rv  = (p == 0) ? rvalid0 : rvalid1;
            rvo = (p == 0) ? rvalid1 : rvalid0;
            checks++;
            if (rv !== 1'b1 || rvo !== 1'b0 || rdata !== expd) begin
                errors++;
                $display("FAIL %s_rd: rvalid=%b other=%b rdata=%h, required 1 0 %h",
                         name, rv, rvo, rdata, expd);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b ack0=%b ack1=%b, required 0 0 0", name, busy, ack0, ack1);
        end
    endtask

    // Both ports write in the same cycle; the first grant goes to port `first`.
    task automatic pair_write(input logic [8:0] a0, input logic [15:0] d0,
                              input logic [8:0] a1, input logic [15:0] d1,
                              input int first, input string name);
        logic [1:0] e1, e2;
        e1 = (first == 0) ? 2'b01 : 2'b10;
        e2 = (first == 0) ? 2'b10 : 2'b01;
        set_port(0, 1'b1, 1'b1, a0, d0);
        set_port(1, 1'b1, 1'b1, a1, d1);
        @(posedge clk); #1;
        checks++;
        if ({ack1, ack0} !== e1) begin
            errors++;
            $display("FAIL %s_first: {ack1,ack0}=%b, required %b", name, {ack1, ack0}, e1);
        end
        set_port(first, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if ({ack1, ack0} !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap: {ack1,ack0}=%b busy=%b, required 00 0", name, {ack1, ack0}, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({ack1, ack0} !== e2) begin
            errors++;
            $display("FAIL %s_second: {ack1,ack0}=%b, required %b", name, {ack1, ack0}, e2);
        end
        set_port(1 - first, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack0, ack1, rvalid0, rvalid1, busy} !== 5'b0 ||
            {dut.ram_e, dut.ram_w, dut.ram_r} !== 3'b0 || dut.last !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: acks/rvalids/busy=%b e/w/r=%b last=%b, required 00000 000 1",
                     {ack0, ack1, rvalid0, rvalid1, busy}, {dut.ram_e, dut.ram_w, dut.ram_r}, dut.last);
        end
        // Reset asserted between clock edges during ISSUE of a read.
        set_port(0, 1'b1, 1'b0, 9'h005, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b1 || dut.ram_r !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_issue: ack0=%b r=%b, required 1 1", ack0, dut.ram_r);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || {dut.ram_e, dut.ram_w, dut.ram_r} !== 3'b0) begin
            errors++;
            $display("FAIL reset_async_issue: ack0=%b busy=%b e/w/r=%b, required 0 0 000",
                     ack0, busy, {dut.ram_e, dut.ram_w, dut.ram_r});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // And during RDATA: the pending rvalid is dropped.
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_rdata_ack: ack0=%b, required 1", ack0);
        end
        set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if (rvalid0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_rdata: rvalid0=%b, required 1", rvalid0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_rdata: rvalid0=%b busy=%b, required 0 0", rvalid0, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_port0_rw();
        access(0, 1'b1, 9'h005, 16'h00A5, 16'h0000, "p0_wr");
        access(0, 1'b0, 9'h005, 16'h0000, 16'h00A5, "p0_rd");
    endtask

    task automatic test_simultaneous();
        do_reset();
        pair_write(9'h010, 16'h1111, 9'h011, 16'h2222, 0, "pair1");
        access(1, 1'b0, 9'h011, 16'h0000, 16'h2222, "pair1_rd1");
        access(0, 1'b0, 9'h010, 16'h0000, 16'h1111, "pair1_rd0");
        pair_write(9'h012, 16'h3333, 9'h013, 16'h4444, 1, "pair2");
        access(0, 1'b0, 9'h012, 16'h0000, 16'h3333, "pair2_rd0");
        access(1, 1'b0, 9'h013, 16'h0000, 16'h4444, "pair2_rd1");
    endtask

    task automatic test_collision();
        pair_write(9'h020, 16'hAAAA, 9'h020, 16'hBBBB, 0, "coll");
        access(0, 1'b0, 9'h020, 16'h0000, 16'hBBBB, "coll_rd");
    endtask

    task automatic test_back_to_back();
        int a1s, a0s, r0s, r1s;
        a1s = n_ack1;
        for (int i = 0; i < 64; i++)
            access(1, 1'b1, 9'(i), 16'(i), 16'h0000, "sweep_wr");
        checks++;
        if (n_ack1 - a1s != 64) begin
            errors++;
            $display("FAIL sweep_ack1_count: %0d, required 64", n_ack1 - a1s);
        end
        a0s = n_ack0; r0s = n_rv0; r1s = n_rv1;
        for (int i = 0; i < 64; i++)
            access(0, 1'b0, 9'(i), 16'h0000, 16'(i), "sweep_rd");
        checks++;
        if (n_ack0 - a0s != 64 || n_rv0 - r0s != 64 || n_rv1 - r1s != 0) begin
            errors++;
            $display("FAIL sweep_rd_counts: ack0=%0d rvalid0=%0d rvalid1=%0d, required 64 64 0",
                     n_ack0 - a0s, n_rv0 - r0s, n_rv1 - r1s);
        end
    endtask

    task automatic test_reset_write();
        access(0, 1'b1, 9'h1FF, 16'h0000, 16'h0000, "fill");
        set_port(0, 1'b1, 1'b1, 9'h1FF, 16'hBEEF);
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b1 || dut.ram_w !== 1'b1) begin
            errors++;
            $display("FAIL rstwr_issue: ack0=%b w=%b, required 1 1", ack0, dut.ram_w);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ack0 !== 1'b0 || dut.ram_e !== 1'b0 || dut.ram_w !== 1'b0) begin
            errors++;
            $display("FAIL rstwr_async: ack0=%b e=%b w=%b, required 0 0 0", ack0, dut.ram_e, dut.ram_w);
        end
        set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        access(0, 1'b0, 9'h1FF, 16'h0000, 16'h0000, "rstwr_rd");
    endtask

    task automatic test_enable();
        logic seen;
        en   = 1'b0;
        seen = 1'b0;
        set_port(0, 1'b1, 1'b1, 9'h030, 16'h5555);
        repeat (4) begin
            @(posedge clk); #1;
            if (ack0 !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL en_block: activity while en=0 seen=%b, required 0", seen);
        end
        en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL en_release: ack0=%b, required 1", ack0);
        end
        set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge clk); #1;
        access(0, 1'b0, 9'h030, 16'h0000, 16'h5555, "en_rd");
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
        set_port(1, 1'b0, 1'b0, 9'h000, 16'h0000);
        test_reset();
        test_port0_rw();
        test_simultaneous();
        test_collision();
        test_back_to_back();
        test_reset_write();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
